mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port memory bus between three requesters: fetch (instruction read), load unit (data read), store buffer (data write).
- Issues one transaction at a time and routes each response back to the requester that owns it.
- On a pipeline flush, discards fetch responses that are still in flight.
- Sits between fetch/LSU/store-buffer and the bus; fetch sees the same req/addr/data/ack protocol it uses today.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, bus data width (INSTRUCTION_WIDTH * FETCH_WIDTH)
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending fetch is forced to win (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch read request, level, held until fetch_ack
fetch_addr  in  ADDR_WIDTH  fetch address
fetch_ack  out  1  one-cycle pulse: fetch_rdata valid
fetch_rdata  out  DATA_WIDTH  fetch read data
fetch_flush  in  1  pipeline flush (commit enable & flush)
load_req  in  1  load read request, level
load_addr  in  ADDR_WIDTH  load address
load_ack  out  1  one-cycle pulse: load_rdata valid
load_rdata  out  DATA_WIDTH  load read data
store_req  in  1  store write request, level
store_addr  in  ADDR_WIDTH  store address
store_wdata  in  DATA_WIDTH  store write data
store_wmask  in  DATA_WIDTH/8  byte enables
store_ack  out  1  one-cycle pulse: write completed
bus_valid  out  1  transaction request
bus_write  out  1  1 = write, 0 = read
bus_addr  out  ADDR_WIDTH  transaction address
bus_wdata  out  DATA_WIDTH  write data
bus_wmask  out  DATA_WIDTH/8  write byte mask
bus_ready  in  1  bus accepts the request this cycle
bus_rsp_valid  in  1  response valid, one per accepted transaction
bus_rsp_rdata  in  DATA_WIDTH  read data
busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- FSM states: IDLE, WAIT_RSP. Reset: IDLE, owner = NONE, discard = 0, starve_cnt = 0; all outputs 0.
- IDLE:
  - Winner is selected combinationally among asserted requests.
  - Priority: store > load > fetch, except when starve_cnt >= STARVE_LIMIT and fetch_req = 1, in which case fetch wins.
  - bus_valid = 1 whenever any request is asserted; bus_write/addr/wdata/wmask driven from the winner. Unused fields are 0 for reads.
  - bus_valid is asserted only in IDLE.
- Acceptance: bus_valid & bus_ready latches owner and goes to WAIT_RSP. If not accepted, winner selection is re-evaluated next cycle and may change.
- Exception: fetch with fetch_flush = 1 in the same cycle is not presented. The request is masked for that cycle and the bus shows the next winner or bus_valid = 0.
- starve_cnt:
  - Increments (saturating at 15) on each accept where fetch_req = 1 but the owner is not fetch.
  - Clears on a fetch accept or when fetch_req = 0.
- WAIT_RSP:
  - Waits for bus_rsp_valid; response latency is at least 1 cycle after accept.
  - On bus_rsp_valid: pulse the owner's ack for that same cycle with rdata = bus_rsp_rdata (combinational pass-through), then return to IDLE.
  - A new request may be accepted in the cycle after the response, not the same cycle, so there is one bus turnaround cycle.
- Flush:
  - fetch_flush while owner = FETCH in WAIT_RSP sets discard.
  - A fetch_flush in the same cycle as the fetch response suppresses that fetch_ack.
  - When the response arrives with discard = 1: fetch_ack is suppressed, discard clears, return to IDLE.
  - Load and store transactions are unaffected by flush.
- Ack outputs:
  - Ack outputs never pulse for a non-owner.
  - *_rdata is 0 when the matching ack = 0.
  - store_rdata does not exist; store_ack carries completion only.
- bus_rsp_valid in IDLE is a protocol error and is ignored; no ack is produced.
- Reset mid-transaction: return to IDLE, discard cleared. Any later stray response is ignored per the rule above.
- Requesters hold req/addr/data stable until their ack, or, for fetch, until flush.

Test Plan:
- Fetch only, addr 0x80000000, bus_ready = 1, response 2 cycles later with data 0x00000013_00000013 -> bus_valid = 1, bus_write = 0 on cycle 0; fetch_ack pulses cycle 2 with that data; busy = 1 for cycles 1..2.
- store_req and fetch_req asserted together, addr 0x100, wmask 0xFF -> store accepted first (bus_write = 1, bus_wmask = 0xFF); store_ack on its response; fetch accepted the cycle after store_ack + 1 turnaround.
- STARVE_LIMIT = 4, store and load requests continuously re-asserted with fetch_req held -> after 4 non-fetch accepts, the 5th accept is fetch; starve_cnt returns to 0.
- Fetch accepted, fetch_flush pulsed in WAIT_RSP, response arrives -> fetch_ack stays 0, FSM back to IDLE; the next fetch request completes normally.
- fetch_flush = 1 with fetch_req = 1 in IDLE and load_req = 0 -> bus_valid = 0 that cycle; with load_req = 1 -> load is presented instead.
- bus_ready held 0 for 3 cycles while load pending, then store_req arrives -> bus switches to store, store accepted when bus_ready = 1; load_ack never pulses early; stray bus_rsp_valid in IDLE produces no ack.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the requesters (fetch, load unit, store buffer), the
// arbiter and the single-port memory bus. The arbiter uses the master modport.
//
// Handshake rules: a transaction is transferred on a cycle where
// bus_valid & bus_ready are both 1. Requester *_req are levels held stable
// (with address/data) until the matching *_ack pulse, or for fetch until a
// flush. Each accepted transaction returns exactly one bus_rsp_valid pulse,
// at least one cycle after acceptance.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ack;
  logic [DATA_WIDTH-1:0] fetch_rdata;
  logic                  fetch_flush;

  logic                  load_req;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  load_ack;
  logic [DATA_WIDTH-1:0] load_rdata;

  logic                  store_req;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [MASK_WIDTH-1:0] store_wmask;
  logic                  store_ack;

  logic                  bus_valid;
  logic                  bus_write;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [MASK_WIDTH-1:0] bus_wmask;
  logic                  bus_ready;
  logic                  bus_rsp_valid;
  logic [DATA_WIDTH-1:0] bus_rsp_rdata;

  logic                  busy;

  modport master (
    input  fetch_req, fetch_addr, fetch_flush,
    input  load_req, load_addr,
    input  store_req, store_addr, store_wdata, store_wmask,
    input  bus_ready, bus_rsp_valid, bus_rsp_rdata,
    output fetch_ack, fetch_rdata, load_ack, load_rdata, store_ack,
    output bus_valid, bus_write, bus_addr, bus_wdata, bus_wmask, busy
  );

  modport slave (
    output fetch_req, fetch_addr, fetch_flush,
    output load_req, load_addr,
    output store_req, store_addr, store_wdata, store_wmask,
    output bus_ready, bus_rsp_valid, bus_rsp_rdata,
    input  fetch_ack, fetch_rdata, load_ack, load_rdata, store_ack,
    input  bus_valid, bus_write, bus_addr, bus_wdata, bus_wmask, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Three-way arbiter (fetch / load / store) for a single-port memory bus with one
// outstanding transaction, fetch anti-starvation, and flush-driven fetch discard.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   arb,
  output logic                dbg_state,
  output logic [1:0]          dbg_owner,
  output logic [3:0]          dbg_starve_cnt
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_WAIT_RSP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

  state_t     state;
  owner_t     owner;
  owner_t     winner;
  logic       discard;
  logic [3:0] starve_cnt;

  logic                  fetch_elig;
  logic                  bus_valid_c;
  logic                  bus_write_c;
  logic [ADDR_WIDTH-1:0] bus_addr_c;
  logic [DATA_WIDTH-1:0] bus_wdata_c;
  logic [MASK_WIDTH-1:0] bus_wmask_c;
  logic                  accept;
  logic                  rsp_fire;
  logic                  fetch_ack_c;
  logic                  load_ack_c;
  logic                  store_ack_c;

  // A fetch being flushed this cycle is masked out of arbitration entirely.
  always_comb begin
    fetch_elig = arb.fetch_req & ~arb.fetch_flush;
    winner     = OWN_NONE;
    if (fetch_elig && (starve_cnt >= STARVE_LIM)) winner = OWN_FETCH;
    else if (arb.store_req)                       winner = OWN_STORE;
    else if (arb.load_req)                        winner = OWN_LOAD;
    else if (fetch_elig)                          winner = OWN_FETCH;
  end

  always_comb begin
    bus_valid_c = 1'b0;
    bus_write_c = 1'b0;
    bus_addr_c  = '0;
    bus_wdata_c = '0;
    bus_wmask_c = '0;
    if (!rst && state == ST_IDLE) begin
      case (winner)
        OWN_STORE: begin
          bus_valid_c = 1'b1;
          bus_write_c = 1'b1;
          bus_addr_c  = arb.store_addr;
          bus_wdata_c = arb.store_wdata;
          bus_wmask_c = arb.store_wmask;
        end
        OWN_LOAD: begin
          bus_valid_c = 1'b1;
          bus_addr_c  = arb.load_addr;
        end
        OWN_FETCH: begin
          bus_valid_c = 1'b1;
          bus_addr_c  = arb.fetch_addr;
        end
        default: ;
      endcase
    end
  end

  assign accept   = bus_valid_c & arb.bus_ready;
  // Responses outside WAIT_RSP are protocol errors and never reach a requester.
  assign rsp_fire = ~rst & (state == ST_WAIT_RSP) & arb.bus_rsp_valid;

  assign fetch_ack_c = rsp_fire & (owner == OWN_FETCH) & ~discard & ~arb.fetch_flush;
  assign load_ack_c  = rsp_fire & (owner == OWN_LOAD);
  assign store_ack_c = rsp_fire & (owner == OWN_STORE);

  assign arb.bus_valid   = bus_valid_c;
  assign arb.bus_write   = bus_write_c;
  assign arb.bus_addr    = bus_addr_c;
  assign arb.bus_wdata   = bus_wdata_c;
  assign arb.bus_wmask   = bus_wmask_c;
  assign arb.fetch_ack   = fetch_ack_c;
  assign arb.fetch_rdata = fetch_ack_c ? arb.bus_rsp_rdata : '0;
  assign arb.load_ack    = load_ack_c;
  assign arb.load_rdata  = load_ack_c ? arb.bus_rsp_rdata : '0;
  assign arb.store_ack   = store_ack_c;
  assign arb.busy        = (state == ST_WAIT_RSP);

  assign dbg_state      = (state == ST_WAIT_RSP);
  assign dbg_owner      = owner;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      discard    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_WAIT_RSP;
            owner <= winner;
          end
        end
        ST_WAIT_RSP: begin
          if (arb.bus_rsp_valid) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            discard <= 1'b0;
          end else if (arb.fetch_flush && owner == OWN_FETCH) begin
            discard <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Counts non-fetch wins while fetch waits; saturates so it cannot wrap.
      if (!arb.fetch_req) begin
        starve_cnt <= '0;
      end else if (accept) begin
        if (winner == OWN_FETCH)     starve_cnt <= '0;
        else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: an IDLE arbitration vector table plus
// hand-written multi-cycle sequences for handshake, starvation and flush cases.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  localparam logic [AW-1:0] F_ADDR = 32'h8000_0000;
  localparam logic [AW-1:0] L_ADDR = 32'h0000_2000;
  localparam logic [AW-1:0] S_ADDR = 32'h0000_0100;
  localparam logic [DW-1:0] S_DATA = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [MW-1:0] S_MASK = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       dbg_state;
  logic [1:0] dbg_owner;
  logic [3:0] dbg_starve_cnt;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .arb            (bif),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  typedef struct {
    logic          fetch_req;
    logic          fetch_flush;
    logic          load_req;
    logic          store_req;
    logic          exp_valid;
    logic          exp_write;
    logic [AW-1:0] exp_addr;
    logic [MW-1:0] exp_wmask;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bif.fetch_req     = 1'b0;
    bif.fetch_addr    = F_ADDR;
    bif.fetch_flush   = 1'b0;
    bif.load_req      = 1'b0;
    bif.load_addr     = L_ADDR;
    bif.store_req     = 1'b0;
    bif.store_addr    = S_ADDR;
    bif.store_wdata   = S_DATA;
    bif.store_wmask   = S_MASK;
    bif.bus_ready     = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_rdata = '0;
  endtask

  task automatic rsp(input logic [DW-1:0] d);
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_rdata = d;
  endtask

  task automatic chk_acks(input string name, input logic f, input logic l, input logic s);
    chk({name, " fetch_ack"}, 64'(bif.fetch_ack), 64'(f));
    chk({name, " load_ack"},  64'(bif.load_ack),  64'(l));
    chk({name, " store_ack"}, 64'(bif.store_ack), 64'(s));
  endtask

  logic [AW-1:0] st_addr[5];
  logic [2:0]    st_ack[5];

  initial begin
    // {fetch_req, fetch_flush, load_req, store_req, valid, write, addr, wmask, wdata}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00,  64'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F_ADDR, 8'h00,  64'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, L_ADDR, 8'h00,  64'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_ADDR, S_MASK, S_DATA};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, L_ADDR, 8'h00,  64'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_ADDR, S_MASK, S_DATA};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_ADDR, S_MASK, S_DATA};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00,  64'h0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, L_ADDR, 8'h00,  64'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_ADDR, S_MASK, S_DATA};

    st_addr = '{S_ADDR, S_ADDR, L_ADDR, L_ADDR, F_ADDR};
    st_ack  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100};  // {fetch, load, store}

    // Reset
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset bus_valid", 64'(bif.bus_valid), 64'h0);
    chk("reset busy", 64'(bif.busy), 64'h0);
    chk("reset starve_cnt", 64'(dbg_starve_cnt), 64'h0);
    chk("reset owner", 64'(dbg_owner), 64'h0);
    chk_acks("reset", 1'b0, 1'b0, 1'b0);

    // IDLE arbitration table, bus_ready = 0 so nothing is accepted
    for (int i = 0; i < 10; i++) begin
      bif.fetch_req   = vecs[i].fetch_req;
      bif.fetch_flush = vecs[i].fetch_flush;
      bif.load_req    = vecs[i].load_req;
      bif.store_req   = vecs[i].store_req;
      settle();
      chk($sformatf("vec%0d bus_valid", i), 64'(bif.bus_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d bus_write", i), 64'(bif.bus_write), 64'(vecs[i].exp_write));
      chk($sformatf("vec%0d bus_addr", i),  64'(bif.bus_addr),  64'(vecs[i].exp_addr));
      chk($sformatf("vec%0d bus_wmask", i), 64'(bif.bus_wmask), 64'(vecs[i].exp_wmask));
      chk($sformatf("vec%0d bus_wdata", i), bif.bus_wdata, vecs[i].exp_wdata);
      tick();
    end
    clear_inputs();
    tick();

    // Fetch only, response two cycles after presentation
    bif.fetch_req = 1'b1;
    bif.bus_ready = 1'b1;
    settle();
    chk("f0 bus_valid", 64'(bif.bus_valid), 64'h1);
    chk("f0 bus_write", 64'(bif.bus_write), 64'h0);
    chk("f0 busy", 64'(bif.busy), 64'h0);
    tick();
    settle();
    chk("f1 busy", 64'(bif.busy), 64'h1);
    chk("f1 bus_valid", 64'(bif.bus_valid), 64'h0);
    chk("f1 fetch_ack", 64'(bif.fetch_ack), 64'h0);
    tick();
    rsp(64'h0000_0013_0000_0013);
    settle();
    chk("f2 busy", 64'(bif.busy), 64'h1);
    chk_acks("f2", 1'b1, 1'b0, 1'b0);
    chk("f2 fetch_rdata", bif.fetch_rdata, 64'h0000_0013_0000_0013);
    chk("f2 load_rdata", bif.load_rdata, 64'h0);
    tick();
    clear_inputs();
    settle();
    chk("f3 busy", 64'(bif.busy), 64'h0);
    chk("f3 fetch_rdata", bif.fetch_rdata, 64'h0);

    // Store beats fetch, fetch follows after the turnaround cycle
    bif.store_req = 1'b1;
    bif.fetch_req = 1'b1;
    bif.bus_ready = 1'b1;
    settle();
    chk("sf0 bus_write", 64'(bif.bus_write), 64'h1);
    chk("sf0 bus_addr", 64'(bif.bus_addr), 64'(S_ADDR));
    chk("sf0 bus_wmask", 64'(bif.bus_wmask), 64'hFF);
    tick();
    settle();
    chk("sf1 bus_valid", 64'(bif.bus_valid), 64'h0);
    tick();
    rsp(64'h1234);
    settle();
    chk_acks("sf2", 1'b0, 1'b0, 1'b1);
    chk("sf2 bus_valid turnaround", 64'(bif.bus_valid), 64'h0);
    tick();
    bif.store_req     = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    settle();
    chk("sf3 bus_valid", 64'(bif.bus_valid), 64'h1);
    chk("sf3 bus_addr", 64'(bif.bus_addr), 64'(F_ADDR));
    chk("sf3 starve_cnt", 64'(dbg_starve_cnt), 64'h1);
    tick();
    rsp(64'h5555_AAAA_0000_FFFF);
    settle();
    chk_acks("sf4", 1'b1, 1'b0, 1'b0);
    chk("sf4 fetch_rdata", bif.fetch_rdata, 64'h5555_AAAA_0000_FFFF);
    tick();
    clear_inputs();
    settle();
    chk("sf5 starve_cnt", 64'(dbg_starve_cnt), 64'h0);

    // Starvation: four non-fetch wins, then fetch is forced through
    bif.fetch_req = 1'b1;
    bif.load_req  = 1'b1;
    bif.store_req = 1'b1;
    bif.bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bif.store_req = 1'b0;
      settle();
      chk($sformatf("starve%0d cnt", k), 64'(dbg_starve_cnt), 64'(k));
      chk($sformatf("starve%0d bus_addr", k), 64'(bif.bus_addr), 64'(st_addr[k]));
      tick();
      rsp(64'(k) + 64'h100);
      settle();
      chk_acks($sformatf("starve%0d", k), st_ack[k][2], st_ack[k][1], st_ack[k][0]);
      tick();
      bif.bus_rsp_valid = 1'b0;
    end
    clear_inputs();
    settle();
    chk("starve end cnt", 64'(dbg_starve_cnt), 64'h0);
    tick();

    // Flush during WAIT_RSP discards the response; next fetch is normal
    bif.fetch_req = 1'b1;
    bif.bus_ready = 1'b1;
    tick();
    bif.fetch_flush = 1'b1;
    bif.fetch_req   = 1'b0;
    settle();
    chk("fl1 fetch_ack", 64'(bif.fetch_ack), 64'h0);
    tick();
    bif.fetch_flush = 1'b0;
    rsp(64'hBAD0_BAD0);
    settle();
    chk_acks("fl2", 1'b0, 1'b0, 1'b0);
    chk("fl2 fetch_rdata", bif.fetch_rdata, 64'h0);
    tick();
    bif.bus_rsp_valid = 1'b0;
    bif.fetch_req     = 1'b1;
    bif.fetch_addr    = F_ADDR + 32'h4;
    settle();
    chk("fl3 busy", 64'(bif.busy), 64'h0);
    chk("fl3 bus_addr", 64'(bif.bus_addr), 64'(F_ADDR + 32'h4));
    tick();
    rsp(64'h0000_0073_0000_0013);
    settle();
    chk_acks("fl4", 1'b1, 1'b0, 1'b0);
    chk("fl4 fetch_rdata", bif.fetch_rdata, 64'h0000_0073_0000_0013);
    tick();
    clear_inputs();

    // Flush in the same cycle as the fetch response
    bif.fetch_req = 1'b1;
    bif.bus_ready = 1'b1;
    tick();
    tick();
    bif.fetch_flush = 1'b1;
    rsp(64'h77);
    settle();
    chk("flsame fetch_ack", 64'(bif.fetch_ack), 64'h0);
    tick();
    clear_inputs();
    settle();
    chk("flsame busy", 64'(bif.busy), 64'h0);

    // Load stalled by bus_ready = 0, stray response ignored, store overtakes
    bif.load_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rsp(64'hFFFF);
      else        bif.bus_rsp_valid = 1'b0;
      settle();
      chk($sformatf("stall%0d bus_addr", c), 64'(bif.bus_addr), 64'(L_ADDR));
      chk_acks($sformatf("stall%0d", c), 1'b0, 1'b0, 1'b0);
      tick();
    end
    bif.bus_rsp_valid = 1'b0;
    bif.store_req = 1'b1;
    bif.bus_ready = 1'b1;
    settle();
    chk("ovt bus_addr", 64'(bif.bus_addr), 64'(S_ADDR));
    chk("ovt bus_write", 64'(bif.bus_write), 64'h1);
    tick();
    rsp(64'h0);
    settle();
    chk_acks("ovt rsp", 1'b0, 1'b0, 1'b1);
    tick();
    bif.store_req     = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    settle();
    chk("ovt load bus_addr", 64'(bif.bus_addr), 64'(L_ADDR));
    tick();
    rsp(64'hCAFE_0000_0000_BEEF);
    settle();
    chk_acks("ovt load", 1'b0, 1'b1, 1'b0);
    chk("ovt load_rdata", bif.load_rdata, 64'hCAFE_0000_0000_BEEF);
    tick();
    clear_inputs();

    // Reset while a load is outstanding; later stray response is ignored
    bif.load_req  = 1'b1;
    bif.bus_ready = 1'b1;
    tick();
    rst = 1'b1;
    bif.load_req = 1'b0;
    tick();
    rst = 1'b0;
    rsp(64'h9999);
    settle();
    chk("rstmid busy", 64'(bif.busy), 64'h0);
    chk_acks("rstmid", 1'b0, 1'b0, 1'b0);
    chk("rstmid load_rdata", bif.load_rdata, 64'h0);
    tick();
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
